trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Purpose:
//   Sequencer that performs machine-mode trap entry and mret return. It drives
//   the CSR file through a simple single-port access interface, updating mepc,
//   mcause and mstatus, reading mtvec / mepc, and finally issues a one-cycle
//   fetch redirect. The pipeline is held off via busy_o for the whole sequence.
//
// Ports:
//   clk_i            in   1  clock, rising edge
//   rst_i            in   1  asynchronous reset, active low
//   exc_req_i        in   1  trap request, held until exc_ack_o
//   exc_cause_i      in  32  trap cause, bit 31 = interrupt
//   exc_pc_i         in  32  PC of the trapping instruction
//   mret_i           in   1  return request, held until mret_ack_o
//   csr_rdata_i      in  32  CSR read data, valid the cycle after csr_re_o
//   csr_addr_o       out 32  CSR address (0 when idle on the port)
//   csr_wdata_o      out 32  CSR write data (0 when not writing)
//   csr_we_o         out  1  CSR write strobe
//   csr_re_o         out  1  CSR read strobe
//   csr_except_o     out  1  marks CSR accesses made by this sequencer
//   exc_ack_o        out  1  trap acceptance pulse
//   mret_ack_o       out  1  mret acceptance pulse
//   busy_o           out  1  sequence in progress (pipeline stall)
//   redirect_valid_o out  1  one-cycle fetch redirect strobe
//   redirect_pc_o    out 32  redirect target
// ---------------------------------------------------------------------------
module trap_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic [31:0] csr_rdata_i,
  output logic [31:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic        csr_except_o,
  output logic        exc_ack_o,
  output logic        mret_ack_o,
  output logic        busy_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [31:0] ADDR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] ADDR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] ADDR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] ADDR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [3:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_RDST,
    T_WRST,
    T_RDVEC,
    M_RDEPC,
    M_RDST,
    M_WRST,
    REDIR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] cause_q;
  logic [31:0] target_q;
  logic        trap_seq_q;

  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;
  logic [31:0] vec_base;
  logic [31:0] vec_offset;
  logic [31:0] vec_target;

  // mstatus rewrite on trap entry: MPIE takes MIE, MIE cleared, MPP = M-mode.
  always_comb begin
    mstatus_trap        = csr_rdata_i;
    mstatus_trap[7]     = csr_rdata_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
  end

  // mstatus rewrite on mret: MIE restored from MPIE, MPIE set, MPP = U-mode.
  always_comb begin
    mstatus_mret        = csr_rdata_i;
    mstatus_mret[3]     = csr_rdata_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b00;
  end

  // The mtvec read issued in T_RDVEC returns data during REDIR, so the trap
  // target is formed combinationally there. Vectored mode only offsets
  // interrupts; the shifted cause is truncated to 32 bits.
  always_comb begin
    vec_base   = {csr_rdata_i[31:2], 2'b00};
    vec_offset = {cause_q[29:0], 2'b00};
    if ((csr_rdata_i[1:0] == 2'b01) && cause_q[31]) begin
      vec_target = vec_base + vec_offset;
    end else begin
      vec_target = vec_base;
    end
  end

  // State register plus the small amount of sequence context: the latched
  // cause, the mret return target and which kind of sequence is running.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cause_q    <= 32'h0;
      target_q   <= 32'h0;
      trap_seq_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (exc_req_i) begin
          trap_seq_q <= 1'b1;
        end else if (mret_i) begin
          trap_seq_q <= 1'b0;
        end
      end
      if (state == T_EPC) begin
        cause_q <= exc_cause_i;
      end
      // mepc read in M_RDEPC arrives here and becomes the return target.
      if (state == M_RDST) begin
        target_q <= csr_rdata_i;
      end
    end
  end

  // Next-state and output decode. Every output defaults to zero so that
  // address/data are quiet whenever no access is in flight. Acceptance
  // pulses are qualified by the reset input so that all outputs read zero
  // the moment reset is asserted, even with a request held in IDLE.
  always_comb begin
    state_next       = state;
    csr_addr_o       = 32'h0;
    csr_wdata_o      = 32'h0;
    csr_we_o         = 1'b0;
    csr_re_o         = 1'b0;
    csr_except_o     = 1'b0;
    exc_ack_o        = 1'b0;
    mret_ack_o       = 1'b0;
    busy_o           = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;

    case (state)
      IDLE: begin
        // A trap takes priority; a simultaneous mret stays pending because
        // its requester keeps holding it.
        if (exc_req_i) begin
          state_next = T_EPC;
          exc_ack_o  = rst_i;
        end else if (mret_i) begin
          state_next = M_RDEPC;
          mret_ack_o = rst_i;
        end
      end

      T_EPC: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_we_o     = 1'b1;
        csr_addr_o   = ADDR_MEPC;
        csr_wdata_o  = {exc_pc_i[31:2], 2'b00};
        state_next   = T_CAUSE;
      end

      T_CAUSE: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_we_o     = 1'b1;
        csr_addr_o   = ADDR_MCAUSE;
        csr_wdata_o  = cause_q;
        state_next   = T_RDST;
      end

      T_RDST: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_re_o     = 1'b1;
        csr_addr_o   = ADDR_MSTATUS;
        state_next   = T_WRST;
      end

      T_WRST: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_we_o     = 1'b1;
        csr_addr_o   = ADDR_MSTATUS;
        csr_wdata_o  = mstatus_trap;
        state_next   = T_RDVEC;
      end

      T_RDVEC: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_re_o     = 1'b1;
        csr_addr_o   = ADDR_MTVEC;
        state_next   = REDIR;
      end

      M_RDEPC: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_re_o     = 1'b1;
        csr_addr_o   = ADDR_MEPC;
        state_next   = M_RDST;
      end

      M_RDST: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_re_o     = 1'b1;
        csr_addr_o   = ADDR_MSTATUS;
        state_next   = M_WRST;
      end

      M_WRST: begin
        busy_o       = 1'b1;
        csr_except_o = 1'b1;
        csr_we_o     = 1'b1;
        csr_addr_o   = ADDR_MSTATUS;
        csr_wdata_o  = mstatus_mret;
        state_next   = REDIR;
      end

      REDIR: begin
        busy_o           = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = trap_seq_q ? vec_target : target_q;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Purpose:
//   Self-checking bench for trap_ctrl. Contains a small CSR file that answers
//   reads one cycle late and applies writes, a step-table model of the trap
//   and mret sequences checked against every output each cycle, and directed
//   scenarios with hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        exc_req_i = 1'b0;
  logic [31:0] exc_cause_i = 32'h0;
  logic [31:0] exc_pc_i = 32'h0;
  logic        mret_i = 1'b0;
  logic [31:0] csr_rdata_i = 32'h0;
  logic [31:0] csr_addr_o;
  logic [31:0] csr_wdata_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic        csr_except_o;
  logic        exc_ack_o;
  logic        mret_ack_o;
  logic        busy_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int checks = 0;
  int errors = 0;

  trap_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .exc_req_i        (exc_req_i),
    .exc_cause_i      (exc_cause_i),
    .exc_pc_i         (exc_pc_i),
    .mret_i           (mret_i),
    .csr_rdata_i      (csr_rdata_i),
    .csr_addr_o       (csr_addr_o),
    .csr_wdata_o      (csr_wdata_o),
    .csr_we_o         (csr_we_o),
    .csr_re_o         (csr_re_o),
    .csr_except_o     (csr_except_o),
    .exc_ack_o        (exc_ack_o),
    .mret_ack_o       (mret_ack_o),
    .busy_o           (busy_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  always #5 clk_i = ~clk_i;

  // CSR file contents; written only by the negedge process below.
  logic [31:0] csr_mem [0:4095];
  logic [31:0] rd_next = 32'hDEAD_BEEF;
  logic [11:0] pre_addr = 12'h0;
  logic [31:0] pre_data = 32'h0;
  int          load_seq = 0;
  int          load_seen = 0;

  // Model context
  int          phase = 0;
  int          step = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cause = 32'h0;
  logic [31:0] m_ret = 32'h0;
  int          cyc = 0;
  int          ack_cyc = 0;
  int          last_lat = 0;
  logic [31:0] last_redir_pc = 32'h0;

  function automatic logic [31:0] trapMstatus(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_1800 | (((ms >> 3) & 32'h1) << 7);
  endfunction

  function automatic logic [31:0] mretMstatus(input logic [31:0] ms);
    return (ms & ~32'h0000_1888) | 32'h0000_0080 | (((ms >> 7) & 32'h1) << 3);
  endfunction

  function automatic logic [31:0] trapTarget(input logic [31:0] mt, input logic [31:0] cause);
    logic [31:0] base;
    base = mt & ~32'h3;
    if (((mt & 32'h3) == 32'h1) && ((cause >> 31) == 32'h1)) begin
      return base + (cause & 32'h7FFF_FFFF) * 32'd4;
    end
    return base;
  endfunction

  // Per-cycle model check and CSR file behaviour, sampled mid-cycle.
  always @(negedge clk_i) begin
    logic        e_eack, e_mack, e_busy, e_exc, e_we, e_re, e_rv;
    logic [31:0] e_addr, e_wdata, e_rpc;
    logic [102:0] exp_v, act_v;
    cyc++;
    if (load_seq != load_seen) begin
      csr_mem[pre_addr] = pre_data;
      load_seen = load_seq;
    end
    e_eack = 1'b0; e_mack = 1'b0; e_busy = 1'b0; e_exc = 1'b0;
    e_we = 1'b0; e_re = 1'b0; e_rv = 1'b0;
    e_addr = 32'h0; e_wdata = 32'h0; e_rpc = 32'h0;
    if (!rst_i) begin
      phase = 0;
      step  = 0;
    end else if (phase == 0) begin
      if (exc_req_i) begin
        e_eack  = 1'b1;
        m_pc    = exc_pc_i;
        m_cause = exc_cause_i;
        phase   = 1;
        step    = 1;
      end else if (mret_i) begin
        e_mack = 1'b1;
        phase  = 2;
        step   = 1;
      end
    end else begin
      e_busy = 1'b1;
      if (phase == 1) begin
        e_exc = (step <= 5);
        case (step)
          1: begin e_we = 1'b1; e_addr = 32'h341; e_wdata = m_pc & ~32'h3; end
          2: begin e_we = 1'b1; e_addr = 32'h342; e_wdata = m_cause; end
          3: begin e_re = 1'b1; e_addr = 32'h300; end
          4: begin e_we = 1'b1; e_addr = 32'h300; e_wdata = trapMstatus(csr_mem[12'h300]); end
          5: begin e_re = 1'b1; e_addr = 32'h305; end
          default: begin e_rv = 1'b1; e_rpc = trapTarget(csr_mem[12'h305], m_cause); end
        endcase
      end else begin
        e_exc = (step <= 3);
        case (step)
          1: begin e_re = 1'b1; e_addr = 32'h341; m_ret = csr_mem[12'h341]; end
          2: begin e_re = 1'b1; e_addr = 32'h300; end
          3: begin e_we = 1'b1; e_addr = 32'h300; e_wdata = mretMstatus(csr_mem[12'h300]); end
          default: begin e_rv = 1'b1; e_rpc = m_ret; end
        endcase
      end
      if ((phase == 1 && step == 6) || (phase == 2 && step == 4)) begin
        phase = 0;
        step  = 0;
      end else begin
        step++;
      end
    end
    exp_v = {e_eack, e_mack, e_busy, e_exc, e_we, e_re, e_rv, e_addr, e_wdata, e_rpc};
    act_v = {exc_ack_o, mret_ack_o, busy_o, csr_except_o, csr_we_o, csr_re_o,
             redirect_valid_o, csr_addr_o, csr_wdata_o, redirect_pc_o};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL cycle_model @%0d: got %h required %h (ack,mack,busy,exc,we,re,rv,addr,wdata,rpc)",
               cyc, act_v, exp_v);
    end
    checks++;
    if (csr_we_o && csr_re_o) begin
      errors++;
      $display("[TB] FAIL we_re_overlap @%0d: got we=%0b re=%0b required not both", cyc, csr_we_o, csr_re_o);
    end
    if (exc_ack_o || mret_ack_o) ack_cyc = cyc;
    if (redirect_valid_o) begin
      last_redir_pc = redirect_pc_o;
      last_lat      = cyc - ack_cyc;
    end
    if (csr_we_o) csr_mem[csr_addr_o[11:0]] = csr_wdata_o;
    rd_next = csr_re_o ? csr_mem[csr_addr_o[11:0]] : 32'hDEAD_BEEF;
  end

  always @(posedge clk_i) csr_rdata_i <= rd_next;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic setCsr(input logic [11:0] addr, input logic [31:0] data);
    pre_addr = addr;
    pre_data = data;
    load_seq++;
    @(negedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic ret,
                               input logic [31:0] pc, input logic [31:0] cause);
    @(posedge clk_i);
    #1;
    exc_req_i   = req;
    mret_i      = ret;
    exc_pc_i    = pc;
    exc_cause_i = cause;
  endtask

  // kind 0: exc_ack_o, 1: mret_ack_o, 2: redirect_valid_o
  task automatic waitFor(input int kind, input string name, output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if ((kind == 0 && exc_ack_o) || (kind == 1 && mret_ack_o) || (kind == 2 && redirect_valid_o)) begin
        seen = 1'b1;
        n = i;
        break;
      end
    end
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL timeout_%s: got no event in 40 cycles required event", name);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    #2 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("reset_busy", {31'h0, busy_o}, 32'h0);
    checkOutput("reset_addr", csr_addr_o, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Direct-mode trap
    setCsr(12'h305, 32'h0000_0100);
    setCsr(12'h300, 32'h0000_0008);
    applyStimulus(1'b1, 1'b0, 32'h0000_0206, 32'h0000_0002);
    waitFor(0, "trap1_ack", n);
    applyStimulus(1'b0, 1'b0, 32'h0000_0206, 32'h0000_0002);
    waitFor(2, "trap1_redir", n);
    checkOutput("trap1_mepc", csr_mem[12'h341], 32'h0000_0204);
    checkOutput("trap1_mcause", csr_mem[12'h342], 32'h0000_0002);
    checkOutput("trap1_mstatus", csr_mem[12'h300], 32'h0000_1880);
    checkOutput("trap1_pc", last_redir_pc, 32'h0000_0100);
    checkOutput("trap1_latency", last_lat, 32'd6);

    // mret back to the saved PC
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h0);
    waitFor(1, "mret1_ack", n);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    waitFor(2, "mret1_redir", n);
    checkOutput("mret1_mstatus", csr_mem[12'h300], 32'h0000_0088);
    checkOutput("mret1_pc", last_redir_pc, 32'h0000_0204);
    checkOutput("mret1_latency", last_lat, 32'd4);

    // Vectored-mode interrupt
    setCsr(12'h305, 32'h0000_0101);
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h8000_0007);
    waitFor(0, "vec_ack", n);
    applyStimulus(1'b0, 1'b0, 32'h0000_0300, 32'h8000_0007);
    waitFor(2, "vec_redir", n);
    checkOutput("vec_pc", last_redir_pc, 32'h0000_011C);
    checkOutput("vec_mcause", csr_mem[12'h342], 32'h8000_0007);
    checkOutput("vec_latency", last_lat, 32'd6);

    // Simultaneous trap and mret: trap first, mret on the next IDLE cycle
    setCsr(12'h305, 32'h0000_0100);
    setCsr(12'h300, 32'h0000_0008);
    applyStimulus(1'b1, 1'b1, 32'h0000_040E, 32'h0000_000B);
    waitFor(0, "both_ack", n);
    checkOutput("both_no_mret_ack", {31'h0, mret_ack_o}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_040E, 32'h0000_000B);
    waitFor(1, "both_mret_ack", n);
    checkOutput("both_mret_delay", n, 32'd7);
    applyStimulus(1'b0, 1'b0, 32'h0000_040E, 32'h0000_000B);
    waitFor(2, "both_redir", n);
    checkOutput("both_pc", last_redir_pc, 32'h0000_040C);
    checkOutput("both_mstatus", csr_mem[12'h300], 32'h0000_0088);

    // Reset asserted in the middle of a trap (during the mstatus read)
    setCsr(12'h300, 32'h0000_0008);
    applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0000_0005);
    waitFor(0, "rst_ack", n);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    checkOutput("rst_mid_flags",
                {25'h0, exc_ack_o, mret_ack_o, busy_o, csr_except_o, csr_we_o, csr_re_o, redirect_valid_o},
                32'h0);
    checkOutput("rst_mid_addr", csr_addr_o, 32'h0);
    checkOutput("rst_mid_wdata", csr_wdata_o, 32'h0);
    exc_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checkOutput("rst_mstatus_kept", csr_mem[12'h300], 32'h0000_0008);
    checkOutput("rst_idle", {31'h0, busy_o}, 32'h0);

    // Fresh trap after reset
    applyStimulus(1'b1, 1'b0, 32'h0000_0206, 32'h0000_0002);
    waitFor(0, "fresh_ack", n);
    applyStimulus(1'b0, 1'b0, 32'h0000_0206, 32'h0000_0002);
    waitFor(2, "fresh_redir", n);
    checkOutput("fresh_pc", last_redir_pc, 32'h0000_0100);
    checkOutput("fresh_latency", last_lat, 32'd6);
    checkOutput("fresh_mstatus", csr_mem[12'h300], 32'h0000_1880);

    repeat (3) @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
